// File: rtl/storer_pkg.sv
// Shared definitions for the storer write path and its fetcher read-side twin.
package storer_pkg;

  // Default widths, shared with the fetcher so both sides of memory agree.
  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam int DEFAULT_ADDR_WIDTH = 8;
  localparam int DEFAULT_FIFO_DEPTH = 4;

  // Storer control states.
  //   ST_RUN   : accepting and committing, flush not yet requested
  //   ST_DRAIN : flush requested, still accepting, finishing when idle
  //   ST_DONE  : finished; nothing accepted or committed until reset
  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

endpackage : storer_pkg

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with a show-ahead head (dout always presents the
// oldest entry). Push into a full FIFO and pop from an empty FIFO are ignored.
// Push and pop in the same cycle leave the occupancy unchanged.
module sync_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          push,
  input  logic                          pop,
  input  logic [DATA_WIDTH-1:0]         din,
  output logic [DATA_WIDTH-1:0]         dout,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          full,
  output logic                          empty
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q;
  logic [PTR_W-1:0]      rd_ptr_q;
  logic [CNT_W-1:0]      count_q;
  logic                  push_ok;
  logic                  pop_ok;

  assign full    = (count_q == CNT_W'(FIFO_DEPTH));
  assign empty   = (count_q == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign dout    = mem_q[rd_ptr_q];
  assign count   = count_q;

  // Storage: written at the write pointer; no reset so it maps to plain RAM.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

  // Pointers and occupancy; depth is a power of two so pointers wrap freely.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule : sync_fifo

// File: rtl/storer.sv
// Storer: accepts a byte stream from the datapath, buffers it in a small FIFO
// and commits it in order to memory through a registered write port. A flush
// drains the buffer and then reports completion; reaching the last memory
// address also completes the run.
module storer
  import storer_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  val_write,
  input  logic [DATA_WIDTH-1:0] in,
  output logic                  full,
  input  logic                  flush,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_data,
  output logic                  done,
  output logic [ADDR_WIDTH:0]   words,
  output logic                  overflow
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  state_e                state_q;
  state_e                state_d;
  logic                  full_q;
  logic                  full_d;
  logic                  mem_we_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic [DATA_WIDTH-1:0] mem_data_q;
  logic                  done_q;
  logic [ADDR_WIDTH:0]   words_q;
  logic                  overflow_q;
  logic                  overflow_d;

  logic                  active;
  logic                  mem_end;
  logic                  push;
  logic                  pop;
  logic                  drop;
  logic                  discard;
  logic [CNT_W-1:0]      fifo_count;
  logic [CNT_W-1:0]      count_d;
  logic [DATA_WIDTH-1:0] fifo_dout;
  logic                  fifo_full;
  logic                  fifo_empty;

  // The word counter doubles as the write pointer; its top bit means the
  // last address has been committed, which stops all further commits.
  assign active  = (state_q != ST_DONE);
  assign mem_end = words_q[ADDR_WIDTH];

  // Acceptance looks only at the registered full flag, so a pop in the same
  // cycle never makes room for a push.
  assign push    = val_write && !full_q && !fifo_full && active;
  assign drop    = val_write && full_q;
  assign pop     = active && !fifo_empty && !mem_end;

  // Occupancy after this edge, used to register full.
  assign count_d = fifo_count + CNT_W'(push) - CNT_W'(pop);

  // Words still buffered (or arriving now) when memory runs out are lost.
  assign discard = active && mem_end && (!fifo_empty || push);

  sync_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (in),
    .dout  (fifo_dout),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Next-state logic: flush starts draining, idle drain or memory end finishes.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN: begin
        if (mem_end) begin
          state_d = ST_DONE;
        end else if (flush) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // Empty FIFO means nothing popped this cycle; a push keeps us going.
        if (mem_end || (fifo_empty && !push)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_DONE;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  // Next values for the registered status flags.
  always_comb begin
    full_d     = (count_d == CNT_W'(FIFO_DEPTH)) || (state_d == ST_DONE);
    overflow_d = overflow_q || drop || discard;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Memory port, word counter and status registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      full_q     <= 1'b0;
      mem_we_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
      done_q     <= 1'b0;
      words_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      full_q     <= full_d;
      mem_we_q   <= pop;
      done_q     <= (state_d == ST_DONE);
      overflow_q <= overflow_d;
      if (pop) begin
        mem_addr_q <= words_q[ADDR_WIDTH-1:0];
        mem_data_q <= fifo_dout;
        words_q    <= words_q + 1'b1;
      end
    end
  end

  assign full     = full_q;
  assign mem_we   = mem_we_q;
  assign mem_addr = mem_addr_q;
  assign mem_data = mem_data_q;
  assign done     = done_q;
  assign words    = words_q;
  assign overflow = overflow_q;

endmodule : storer
